// File: rtl/dm.sv
// dm: word-organised little-endian data memory with byte/half/word stores and extending loads
module dm #(
  parameter int DEPTH = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_memwrite,
  input  logic [1:0]  M_storeop,
  input  logic [2:0]  M_loadop,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  output logic [31:0] M_dm,
  output logic        M_dm_err
);
  logic [31:0] mem_q [DEPTH];
  logic [11:0] idx;
  logic [1:0]  b;
  logic        in_range, st_en, st_ok, ld_kind, ld_ok;
  logic [3:0]  be;
  logic [31:0] wrep, word;
  logic [15:0] half;
  logic [7:0]  byte_v;
  assign idx      = M_addr[13:2];
  assign b        = M_addr[1:0];
  assign in_range = (M_addr[31:14] == '0) && ({20'd0, idx} < 32'(DEPTH));
  assign st_en    = M_memwrite && (M_storeop != 2'b11);
  assign st_ok    = in_range && (M_storeop == 2'b00 ? b == 2'b00 :
                                 M_storeop == 2'b01 ? !b[0] : 1'b1);
  assign ld_kind  = M_loadop <= 3'd4;
  assign ld_ok    = ld_kind && in_range && (M_loadop == 3'd0 ? b == 2'b00 :
                                            M_loadop <= 3'd2 ? !b[0] : 1'b1);
  assign M_dm_err = (st_en && !st_ok) || (ld_kind && !ld_ok);
  assign be       = M_storeop == 2'b00 ? 4'hF :
                    M_storeop == 2'b01 ? (b[1] ? 4'hC : 4'h3) : 4'b0001 << b;
  assign wrep     = M_storeop == 2'b00 ? M_wdata :
                    M_storeop == 2'b01 ? {2{M_wdata[15:0]}} : {4{M_wdata[7:0]}};
  assign word     = in_range ? mem_q[idx] : '0;
  assign half     = b[1] ? word[31:16] : word[15:0];
  assign byte_v   = 8'(word >> {b, 3'b000});
  always_comb begin
    M_dm = '0;
    if (ld_ok)
      M_dm = M_loadop == 3'd0 ? word :
             M_loadop == 3'd1 ? {{16{half[15]}}, half} :
             M_loadop == 3'd2 ? {16'd0, half} :
             M_loadop == 3'd3 ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (st_en && st_ok) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dm.sv
// tb_dm: directed and randomized checks of dm against a byte-array reference model
module tb_dm;
  logic        clk = 1'b0;
  logic        reset, M_memwrite;
  logic [1:0]  M_storeop;
  logic [2:0]  M_loadop;
  logic [31:0] M_addr, M_wdata, M_dm;
  logic        M_dm_err;
  logic [7:0]  ref_mem [12288];
  int          total = 0, fails = 0;

  dm dut (
    .clk(clk), .reset(reset), .M_memwrite(M_memwrite), .M_storeop(M_storeop),
    .M_loadop(M_loadop), .M_addr(M_addr), .M_wdata(M_wdata),
    .M_dm(M_dm), .M_dm_err(M_dm_err)
  );

  always #5 clk = ~clk;

  function automatic int st_width(input logic [1:0] op);
    return op == 2'd0 ? 4 : op == 2'd1 ? 2 : 1;
  endfunction

  function automatic int ld_width(input logic [2:0] op);
    return op == 3'd0 ? 4 : (op == 3'd1 || op == 3'd2) ? 2 : 1;
  endfunction

  function automatic bit acc_ok(input logic [31:0] a, input int w);
    return (a < 32'h3000) && (a % w == 0);
  endfunction

  function automatic logic [31:0] exp_dm(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    int w;
    if (op > 3'd4) return 32'd0;
    w = ld_width(op);
    if (!acc_ok(a, w)) return 32'd0;
    v = 32'd0;
    for (int k = 0; k < w; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    if (op == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
    return v;
  endfunction

  function automatic logic exp_err(input logic we, input logic [1:0] sop,
                                   input logic [2:0] lop, input logic [31:0] a);
    logic e;
    e = 1'b0;
    if (we && sop != 2'b11 && !acc_ok(a, st_width(sop))) e = 1'b1;
    if (lop <= 3'd4 && !acc_ok(a, ld_width(lop))) e = 1'b1;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic we, input logic [1:0] sop,
                     input logic [2:0] lop, input logic [31:0] a, input logic [31:0] wd,
                     input bit chk);
    logic [31:0] e_dm;
    logic        e_err;
    reset = rst; M_memwrite = we; M_storeop = sop; M_loadop = lop; M_addr = a; M_wdata = wd;
    #1;
    if (chk) begin
      e_dm = exp_dm(lop, a);
      e_err = exp_err(we, sop, lop, a);
      total++;
      assert (M_dm === e_dm) else begin
        fails++;
        $error("FAIL %s M_dm: got %h expected %h", tag, M_dm, e_dm);
      end
      total++;
      assert (M_dm_err === e_err) else begin
        fails++;
        $error("FAIL %s M_dm_err: got %b expected %b", tag, M_dm_err, e_err);
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 12288; k++) ref_mem[k] = 8'd0;
    end else if (we && sop != 2'b11 && acc_ok(a, st_width(sop))) begin
      for (int k = 0; k < st_width(sop); k++) ref_mem[a + k] = 8'(wd >> (8 * k));
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 12288; k++) ref_mem[k] = 8'd0;
    @(negedge clk);
    cyc("rst",       1, 0, 3, 7, 0, 0, 0);
    cyc("rst_lw0",   0, 0, 3, 0, 32'h0000, 0, 1);
    cyc("rst_lwtop", 0, 0, 3, 0, 32'h2FFC, 0, 1);
    cyc("rst_lwmid", 0, 0, 3, 0, 32'h1234, 0, 1);
    cyc("sw10",      0, 1, 0, 7, 32'h0010, 32'h89ABCDEF, 1);
    cyc("lw10",      0, 0, 3, 0, 32'h0010, 0, 1);
    cyc("lb13",      0, 0, 3, 3, 32'h0013, 0, 1);
    cyc("lbu13",     0, 0, 3, 4, 32'h0013, 0, 1);
    cyc("lh12",      0, 0, 3, 1, 32'h0012, 0, 1);
    cyc("lhu10",     0, 0, 3, 2, 32'h0010, 0, 1);
    cyc("sw20",      0, 1, 0, 7, 32'h0020, 32'h0, 1);
    cyc("sb21",      0, 1, 2, 7, 32'h0021, 32'h123456AA, 1);
    cyc("sh22",      0, 1, 1, 7, 32'h0022, 32'h98765566, 1);
    cyc("lw20",      0, 0, 3, 0, 32'h0020, 0, 1);
    cyc("sw30pre",   0, 1, 0, 7, 32'h0030, 32'h22222222, 1);
    cyc("rdw30",     0, 1, 0, 0, 32'h0030, 32'h11111111, 1);
    cyc("lw30",      0, 0, 3, 0, 32'h0030, 0, 1);
    cyc("sw40pre",   0, 1, 0, 7, 32'h0040, 32'hA5A5C3C3, 1);
    cyc("sw41",      0, 1, 0, 7, 32'h0041, 32'hFFFFFFFF, 1);
    cyc("sh43",      0, 1, 1, 7, 32'h0043, 32'hFFFFFFFF, 1);
    cyc("lw40",      0, 0, 3, 0, 32'h0040, 0, 1);
    cyc("sw3000",    0, 1, 0, 7, 32'h3000, 32'h12345678, 1);
    cyc("lw3000",    0, 0, 3, 0, 32'h3000, 0, 1);
    cyc("lwhigh",    0, 0, 3, 0, 32'h0001_0040, 0, 1);
    cyc("badop",     0, 0, 3, 5, 32'h0041, 0, 1);
    cyc("sw50rst",   1, 1, 0, 7, 32'h0050, 32'hDEADBEEF, 1);
    cyc("lw50a",     0, 0, 3, 0, 32'h0050, 0, 1);
    cyc("sw50",      0, 1, 0, 7, 32'h0050, 32'hDEADBEEF, 1);
    cyc("lw50b",     0, 0, 3, 0, 32'h0050, 0, 1);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom_range(32'h2FF0, 32'h3010)
                                       : $urandom_range(0, 32'h7F);
      if ($urandom_range(0, 31) == 0) a = a | 32'h0001_0000;
      cyc("rand", $urandom_range(0, 99) == 0, 1'($urandom), 2'($urandom),
          3'($urandom_range(0, 5)), a, $urandom, 1);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
